sample_framer: RTL and testbench
================================

Name: sample_framer

Overview:
Upstream stage of the window-metric counter. Accepts 8-bit ADC samples with a valid strobe, buffers them in a small FIFO and, on a start request, issues a frame of exactly M samples to the counter. Emits a one-cycle clear pulse ahead of each frame so the counter restarts cleanly. Reports frame completion, overflow and underflow.

Parameters:
DW, 8, sample width in bits.
DEPTH, 16, FIFO depth in entries; power of two, 2..256.
AW, 4, FIFO address width; log2(DEPTH).

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-high reset.
adc_data  input  DW  incoming sample.
adc_valid  input  1  adc_data valid this cycle.
start  input  1  frame request; sampled only in IDLE.
m_len  input  8  frame length M; latched on accepted start.
clr  output  1  one-cycle pulse to the counter reset, asserted in ARM.
out_data  output  DW  sample to the counter input.
out_valid  output  1  out_data is a frame sample this cycle.
frame_done  output  1  one-cycle pulse after the last sample is issued.
busy  output  1  high in every state except IDLE.
fifo_full  output  1  FIFO holds DEPTH entries.
fifo_empty  output  1  FIFO holds 0 entries.
overflow  output  1  sticky; a sample was dropped because the FIFO was full.
underflow  output  1  sticky; STREAM found the FIFO empty.

Behaviour:
- Reset: all outputs 0 except fifo_empty=1; FIFO pointers and count 0; state IDLE; latched M = 0.
- FIFO: write when adc_valid && !fifo_full; read when the FSM pops. Count width AW+1. Read and write in the same cycle while full: both proceed and count is unchanged. adc_valid while full with no read: sample dropped, overflow set. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ARM, STREAM, DONE.
- IDLE: if start && m_len!=0, latch M and go to ARM. start with m_len==0 is ignored and the FSM stays in IDLE. start is ignored in every other state.
- ARM: clr=1 for exactly one cycle, then go to STREAM. The issued-sample counter k is cleared to 0.
- STREAM: when !fifo_empty, pop one entry. out_data is registered from the FIFO head and out_valid=1 in the following cycle. k increments on each pop; after pop k==M-1, go to DONE. Latency from pop to out_valid is 1 cycle. No gap is introduced while data is available.
- STREAM with the FIFO empty: no pop, out_valid=0 next cycle, underflow set, and the FSM remains in STREAM.
- DONE: frame_done=1 for one cycle, out_valid=0, then go to IDLE. The last out_valid and frame_done never share a cycle; frame_done follows it.
- The FIFO keeps accepting samples in every state, including IDLE.
- Asserting rst mid-frame aborts the frame immediately, flushes the FIFO and clears the sticky flags.
- overflow and underflow clear only on rst.

Optional Feature:
Macro HOLD_LAST_EN.
- Defined: on a STREAM underflow cycle, out_valid=1 and out_data repeats the last issued sample; this counts toward k and underflow is still set. If underflow occurs before any pop in the frame, the repeated value is 0. Frame length in cycles is then always exactly M.
- Undefined: underflow stalls as described under Behaviour; out_valid=0 and k is unchanged.

Test Plan:
- Reset: assert rst mid-STREAM with 5 entries queued -> busy=0, fifo_empty=1, out_valid=0, overflow=0 immediately.
- Basic frame: preload 4 samples 10,20,30,40, then start with m_len=4 -> clr pulse, then out_valid on 4 consecutive cycles with data 10,20,30,40, then frame_done one cycle later, then IDLE.
- Overflow: write 17 samples with no frame running, DEPTH=16 -> fifo_full=1, overflow=1; a following M=16 frame issues the first 16 samples in order.
- Underflow stall, macro off: preload 2 samples, start with m_len=3, feed the third sample 5 cycles later -> out_valid low during the gap, underflow=1, third sample issued, then frame_done.
- Underflow hold, macro on: same stimulus -> out_valid continuous; third output repeats the second sample; frame_done after 3 outputs.
- Corner starts: start with m_len=0 -> no clr and busy stays 0. start asserted during STREAM -> ignored. Simultaneous read and write while full -> count stays 16 and overflow stays 0.

Source files
------------

// File: rtl/sample_framer.sv
// sample_framer: buffers ADC samples in a FIFO and issues clr-prefixed frames of M samples.
// Define HOLD_LAST_EN to repeat the last issued sample on underflow instead of stalling.
module sample_framer #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] adc_data,
   input  logic          adc_valid,
   input  logic          start,
   input  logic [7:0]    m_len,
   output logic          clr,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   output logic          frame_done,
   output logic          busy,
   output logic          fifo_full,
   output logic          fifo_empty,
   output logic          overflow,
   output logic          underflow
);
   typedef enum logic [1:0] {IDLE, ARM, STREAM, DONE} state_t;
   state_t state_q, state_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0] cnt_q, cnt_d;
   logic [7:0] m_q, m_d, k_q, k_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic out_valid_q, out_valid_d, frame_done_q, frame_done_d;
   logic overflow_q, overflow_d, underflow_q, underflow_d;
   logic wr, rd, hold, adv;
   assign fifo_full  = cnt_q == (AW+1)'(DEPTH);
   assign fifo_empty = cnt_q == '0;
   assign rd = state_q == STREAM && !fifo_empty;
   // A full FIFO still accepts a sample when the same cycle frees a slot.
   assign wr = adc_valid && (!fifo_full || rd);
`ifdef HOLD_LAST_EN
   assign hold = state_q == STREAM && fifo_empty;
`else
   assign hold = 1'b0;
`endif
   assign adv = rd || hold;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = (start && m_len != 8'd0) ? ARM : IDLE;
         ARM:     state_d = STREAM;
         STREAM:  state_d = (adv && k_q == m_q - 8'd1) ? DONE : STREAM;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      clr  = state_q == ARM;
      busy = state_q != IDLE;
   end
   always_comb begin
      wptr_d       = wr ? wptr_q + 1'b1 : wptr_q;
      rptr_d       = rd ? rptr_q + 1'b1 : rptr_q;
      cnt_d        = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
      m_d          = (state_q == IDLE && start && m_len != 8'd0) ? m_len : m_q;
      k_d          = state_q == ARM ? 8'd0 : adv ? k_q + 8'd1 : k_q;
      out_valid_d  = adv;
      out_data_d   = state_q == ARM ? '0 : rd ? mem_q[rptr_q] : out_data_q;
      frame_done_d = state_q == DONE;
      overflow_d   = overflow_q | (adc_valid && fifo_full && !rd);
      underflow_d  = underflow_q | (state_q == STREAM && fifo_empty);
   end
   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= adc_data;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         cnt_q        <= '0;
         m_q          <= '0;
         k_q          <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         cnt_q        <= cnt_d;
         m_q          <= m_d;
         k_q          <= k_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;
endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: directed and random frames checked against a queue-based reference model.
module tb_sample_framer;
`ifdef HOLD_LAST_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] adc_data = '0, m_len = '0, out_data;
   logic adc_valid = 1'b0, start = 1'b0;
   logic clr, out_valid, frame_done, busy, fifo_full, fifo_empty, overflow, underflow;
   int vectors = 0, miscompares = 0;
   logic [7:0] q[$];
   logic [7:0] seen[$];
   int phase = 0, issued = 0, mlat = 0, nclr = 0, nfd = 0;
   logic m_ovf = 0, m_unf = 0, m_fd = 0, m_ov = 0;
   logic [7:0] m_data = '0;

   sample_framer dut (
      .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .start(start),
      .m_len(m_len), .clr(clr), .out_data(out_data), .out_valid(out_valid),
      .frame_done(frame_done), .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all();
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_data);
      chk("frame_done", frame_done, m_fd);
      chk("clr", clr, phase == 1);
      chk("busy", busy, phase != 0);
      chk("fifo_full", fifo_full, q.size() == 16);
      chk("fifo_empty", fifo_empty, q.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic s, input logic [7:0] m);
      bit pop, stp, push;
      adc_valid = v; adc_data = d; start = s; m_len = m;
      pop  = phase == 2 && q.size() > 0;
      stp  = phase == 2 && (q.size() > 0 || HOLD);
      push = v && (q.size() < 16 || pop);
      if (v && !push) m_ovf = 1;
      if (phase == 2 && q.size() == 0) m_unf = 1;
      m_fd = phase == 3;
      m_ov = stp;
      if (phase == 1) m_data = 0;
      if (pop) m_data = q.pop_front();
      if (push) q.push_back(d);
      case (phase)
         0: if (s && m != 0) begin mlat = m; phase = 1; end
         1: begin issued = 0; phase = 2; end
         2: if (stp) begin issued++; if (issued == mlat) phase = 3; end
         default: phase = 0;
      endcase
      @(posedge clk); #1;
      if (out_valid) seen.push_back(out_data);
      if (clr) nclr++;
      if (frame_done) nfd++;
      chk_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      #2 rst = 1; adc_valid = 0; start = 0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_overflow", overflow, 0);
      q.delete(); seen.delete();
      phase = 0; issued = 0; mlat = 0; nclr = 0; nfd = 0;
      m_ovf = 0; m_unf = 0; m_fd = 0; m_ov = 0; m_data = 0;
      @(posedge clk); #1 rst = 0;
      chk_all();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_all();
      rst = 0;
      // basic frame
      for (int i = 1; i <= 4; i++) step(1, 8'(10 * i), 0, 0);
      step(0, 0, 1, 4);
      idle(8);
      chk("basic_n", seen.size(), 4);
      for (int i = 0; i < 4 && i < seen.size(); i++) chk("basic_data", seen[i], 10 * (i + 1));
      chk("basic_clr", nclr, 1);
      chk("basic_done", nfd, 1);
      // overflow then M=16 frame
      seen.delete();
      for (int i = 1; i <= 17; i++) step(1, 8'(i), 0, 0);
      chk("ovf_full", fifo_full, 1);
      chk("ovf_flag", overflow, 1);
      step(0, 0, 1, 16);
      idle(20);
      chk("ovf_n", seen.size(), 16);
      for (int i = 0; i < 16 && i < seen.size(); i++) chk("ovf_data", seen[i], i + 1);
      // underflow
      do_reset();
      step(1, 5, 0, 0); step(1, 6, 0, 0);
      step(0, 0, 1, 3);
      idle(5);
      step(1, 7, 0, 0);
      idle(5);
      chk("unf_flag", underflow, 1);
      chk("unf_n", seen.size(), 3);
      if (seen.size() == 3) chk("unf_third", seen[2], HOLD ? 6 : 7);
      chk("unf_done", nfd, 1);
      // m_len==0 start ignored
      do_reset();
      step(0, 0, 1, 0);
      chk("m0_busy", busy, 0);
      idle(2);
      chk("m0_clr", nclr, 0);
      // full with simultaneous read/write, start ignored mid-stream
      for (int i = 0; i < 16; i++) step(1, 8'(100 + i), 0, 0);
      step(0, 0, 1, 8);
      step(0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 8'(200 + i), 1, 3);
      idle(4);
      chk("rw_full", fifo_full, 1);
      chk("rw_ovf", overflow, 0);
      chk("rw_done", nfd, 1);
      // reset mid-stream with entries queued
      do_reset();
      for (int i = 0; i < 7; i++) step(1, 8'(i), 0, 0);
      step(0, 0, 1, 8);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      chk("mid_busy", busy, 1);
      do_reset();
      // random traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0, 8'($urandom_range(0, 20)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
